vga_scanout: RTL and testbench

Display-side consumer of the pixel-write interface driven by the screen-clear/draw datapaths (x[7:0], y[6:0], colour[2:0], plot). The block stores written pixels in an internal 160x120x3 framebuffer and continuously reads it out in raster order. It generates RGB, hsync, vsync and blank for the VGA DAC and sits between the drawing FSMs and the board's VGA pins.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/fb_ram.sv | 36 +++
 rtl/vga_scanout.sv | 183 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, pixel/coordinate types and the framebuffer address helper
// for the VGA scanout block.
//
// Contents:
//   H_* / V_* : raster timing in pixels / lines, plus the H_TOTAL and V_TOTAL sums
//   colour_t  : 3-bit {r,g,b} pixel value, with BLACK and WHITE constants
//   xcoord_t, ycoord_t, fb_addr_t : write coordinates and the linear framebuffer address
//   hcount_t, vcount_t : raster counter types (both need 8 bits to reach 199 and 129)
//   fb_addr() : row-major address y*H_ACTIVE + x, built from shifts
package vga_pkg;

    localparam int unsigned H_ACTIVE = 160;
    localparam int unsigned H_FP     = 4;
    localparam int unsigned H_SYNC   = 24;
    localparam int unsigned H_BP     = 12;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 120;
    localparam int unsigned V_FP     = 5;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 3;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned FB_DEPTH = H_ACTIVE * V_ACTIVE;

    typedef logic [2:0]  colour_t;
    typedef logic [7:0]  xcoord_t;
    typedef logic [6:0]  ycoord_t;
    typedef logic [14:0] fb_addr_t;
    typedef logic [7:0]  hcount_t;
    typedef logic [7:0]  vcount_t;

    localparam colour_t BLACK = 3'd0;
    localparam colour_t WHITE = 3'd7;

    // y*160 as (y<<7)+(y<<5); the largest legal address is 19199, well inside 15 bits.
    function automatic fb_addr_t fb_addr(input ycoord_t row, input xcoord_t col);
        fb_addr_t row_w;
        row_w = fb_addr_t'(row);
        return (row_w << 7) + (row_w << 5) + fb_addr_t'(col);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port and one registered read port.
// On a clash between the read and write addresses the read returns the old contents.
// The array is not reset, so the tools can map it onto block RAM.
//
// Ports:
//   clock : clock for both ports
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, registered, valid one clock after raddr
module fb_ram
    import vga_pkg::*;
#(
    parameter int unsigned Depth = FB_DEPTH
) (
    input  logic        clock,
    input  logic        we,
    input  logic [14:0] waddr,
    input  logic [2:0]  wdata,
    input  logic [14:0] raddr,
    output logic [2:0]  rdata
);

    colour_t mem [Depth];

    // Read and write live in the same process, so the read sees the value from before the
    // write.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: stores pixels from the draw/clear datapaths in a 160x120x3 framebuffer and
// reads them out in raster order, together with hsync, vsync, blank and frame_start.
// All outputs are registered. They appear 2 clocks after the counters reach a position:
// stage 1 is the RAM read plus the delayed decode, and stage 2 is the output register.
//
// Optional build macro SCANOUT_TESTPATTERN_EN adds the test_mode input. When it is high,
// active pixels show 8-colour vertical bars (colour = hcount % 8) in place of framebuffer
// data.
//
// Ports:
//   clock, resetb   : clock and asynchronous active-low reset
//   pix_en          : pixel-rate strobe; the raster counters advance only when it is high
//   x, y, colour    : write column, row and {r,g,b} colour
//   plot            : write strobe; out-of-range coordinates are dropped
//   test_mode       : (SCANOUT_TESTPATTERN_EN only) selects the bar pattern
//   vga_r/g/b       : pixel colour, 000 outside the active region
//   hsync, vsync    : active-low sync pulses
//   blank           : high outside the active region
//   frame_start     : one-clock pulse aligned with pixel (0,0)
module vga_scanout
    import vga_pkg::*;
(
    input  logic       clock,
    input  logic       resetb,
    input  logic       pix_en,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
`ifdef SCANOUT_TESTPATTERN_EN
    input  logic       test_mode,
`endif
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       frame_start
);

    localparam hcount_t HLast      = hcount_t'(H_TOTAL - 1);
    localparam vcount_t VLast      = vcount_t'(V_TOTAL - 1);
    localparam hcount_t HAct       = hcount_t'(H_ACTIVE);
    localparam vcount_t VAct       = vcount_t'(V_ACTIVE);
    localparam hcount_t HSyncStart = hcount_t'(H_ACTIVE + H_FP);
    localparam hcount_t HSyncEnd   = hcount_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam vcount_t VSyncStart = vcount_t'(V_ACTIVE + V_FP);
    localparam vcount_t VSyncEnd   = vcount_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam xcoord_t XLimit     = xcoord_t'(H_ACTIVE);
    localparam ycoord_t YLimit     = ycoord_t'(V_ACTIVE);

    // Raster counters.
    hcount_t hcount_q, hcount_d;
    vcount_t vcount_q, vcount_d;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == HLast) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 8'd1;
            end else begin
                hcount_d = hcount_q + 8'd1;
            end
        end
    end

    // Decode of the current raster position, and the write-port qualification.
    logic     active;
    logic     hsync_n;
    logic     vsync_n;
    logic     fs_raw;
    logic     wr_en;
    fb_addr_t rd_addr;
    fb_addr_t wr_addr;
    colour_t  rd_data;

    always_comb begin
        active  = (hcount_q < HAct) && (vcount_q < VAct);
        hsync_n = !((hcount_q >= HSyncStart) && (hcount_q < HSyncEnd));
        vsync_n = !((vcount_q >= VSyncStart) && (vcount_q < VSyncEnd));
        fs_raw  = (hcount_q == '0) && (vcount_q == '0) && pix_en;
        // Inside the active region vcount < 120, so its low 7 bits hold the whole row.
        rd_addr = active ? fb_addr(vcount_q[6:0], hcount_q) : '0;
        wr_en   = plot && (x < XLimit) && (y < YLimit);
        wr_addr = fb_addr(y, x);
    end

    fb_ram #(
        .Depth(FB_DEPTH)
    ) u_fb_ram (
        .clock(clock),
        .we   (wr_en),
        .waddr(wr_addr),
        .wdata(colour),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    // Stage 1: timing decode delayed one clock, so it lines up with rd_data.
    logic    s1_active_q;
    logic    s1_hsync_q;
    logic    s1_vsync_q;
    logic    s1_fs_q;
`ifdef SCANOUT_TESTPATTERN_EN
    colour_t s1_bar_q;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1_active_q <= 1'b0;
            s1_hsync_q  <= 1'b1;
            s1_vsync_q  <= 1'b1;
            s1_fs_q     <= 1'b0;
`ifdef SCANOUT_TESTPATTERN_EN
            s1_bar_q    <= BLACK;
`endif
        end else begin
            s1_active_q <= active;
            s1_hsync_q  <= hsync_n;
            s1_vsync_q  <= vsync_n;
            s1_fs_q     <= fs_raw;
`ifdef SCANOUT_TESTPATTERN_EN
            s1_bar_q    <= colour_t'(hcount_q[2:0]);
`endif
        end
    end

    // Stage 2: output register.
    colour_t rgb_d, rgb_q;
    logic    hsync_q;
    logic    vsync_q;
    logic    blank_q;
    logic    fs_q;

    always_comb begin
        rgb_d = BLACK;
        if (s1_active_q) begin
`ifdef SCANOUT_TESTPATTERN_EN
            rgb_d = test_mode ? s1_bar_q : rd_data;
`else
            rgb_d = rd_data;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rgb_q   <= BLACK;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= s1_hsync_q;
            vsync_q <= s1_vsync_q;
            blank_q <= !s1_active_q;
            fs_q    <= s1_fs_q;
        end
    end

    assign vga_r       = rgb_q[2];
    assign vga_g       = rgb_q[1];
    assign vga_b       = rgb_q[0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout (default build, without the test pattern).
// A behavioural model holds the framebuffer as an int array and the raster position as plain
// integers. It predicts every output on every clock through a two-entry delay.
module tb_vga_scanout;

    logic       clock  = 1'b0;
    logic       resetb = 1'b1;
    logic       pix_en;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start;

    vga_scanout dut (
        .clock      (clock),
        .resetb     (resetb),
        .pix_en     (pix_en),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Observed/expected vector: {r,g,b,hsync,vsync,blank,frame_start}
    typedef struct {
        logic [6:0] sig;
        int         h;
        int         v;
        bit         act;
    } pix_t;

    localparam logic [6:0] RstSig = 7'b000_1110;

    int   fb [19200];
    int   mh = 0, mv = 0;
    pix_t s1, exp_p, rst_pix;
    int   cyc = 0;
    int   frame_no = 0;

    int   hs_fall, hs_period, hs_width, vs_fall, vs_width, fs_first, fs_prev, fs_last;
    bit   prev_hs = 1'b1, prev_vs = 1'b1;

    function automatic void meas_clear();
        hs_fall = -1; hs_period = -1; hs_width = -1;
        vs_fall = -1; vs_width = -1;
        fs_first = -1; fs_prev = -1; fs_last = -1;
    endfunction

    // What a pixel position should look like on the pins.
    function automatic pix_t view(input int h, input int v, input bit pe);
        pix_t p;
        logic [2:0] c;
        p.h   = h;
        p.v   = v;
        p.act = (h < 160) && (v < 120);
        c     = p.act ? 3'(fb[v * 160 + h]) : 3'd0;
        p.sig = {c, !(h >= 164 && h < 188), !(v >= 125 && v < 127), !p.act,
                 (h == 0 && v == 0 && pe)};
        return p;
    endfunction

    function automatic void model_reset();
        s1    = rst_pix;
        exp_p = rst_pix;
        mh    = 0;
        mv    = 0;
    endfunction

    function automatic logic [6:0] pins();
        return {vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start};
    endfunction

    // One clock: predict with the present inputs, clock the DUT, then compare and measure.
    task automatic tick();
        logic [6:0] got;
        logic [2:0] rgb;
        if (resetb) begin
            exp_p = s1;
            s1    = view(mh, mv, pix_en);   // looked up before this clock's write lands
            if (pix_en) begin
                mh++;
                if (mh == 200) begin
                    mh = 0;
                    mv = (mv == 129) ? 0 : mv + 1;
                end
            end
        end else begin
            exp_p = rst_pix;
        end
        if (plot && x < 160 && y < 120) fb[int'(y) * 160 + int'(x)] = int'(colour);
        @(posedge clock);
        #1;
        cyc++;
        got = pins();
        check_val("px", {25'd0, got}, {25'd0, exp_p.sig});

        if (exp_p.sig[0]) frame_no++;
        if (exp_p.act) begin
            rgb = got[6:4];
            if (exp_p.h == 0 && exp_p.v == 0)     check_val("pix_0_0", {29'd0, rgb}, 5);
            if (exp_p.h == 159 && exp_p.v == 119) check_val("pix_159_119", {29'd0, rgb}, 3);
            if (exp_p.h == 3 && exp_p.v == 5)     check_val("pix_3_5", {29'd0, rgb}, 2);
            if (exp_p.h == 0 && exp_p.v == 5)     check_val("no_alias_0_5", {29'd0, rgb}, 4);
            if (exp_p.h == 0 && exp_p.v == 6)     check_val("no_alias_0_6", {29'd0, rgb}, 4);
            if (exp_p.h == 3 && exp_p.v == 0)     check_val("no_alias_3_0", {29'd0, rgb}, 4);
            if (exp_p.h == 10 && exp_p.v == 20)
                check_val("rbw_10_20", {29'd0, rgb}, (frame_no >= 2) ? 6 : 1);
        end
        if (resetb && exp_p.h == 160 && exp_p.v == 0)
            check_val("edge_160", {28'd0, got[6:4], got[1]}, 4'b0001);

        if (prev_hs && !got[3]) begin
            if (hs_fall >= 0) hs_period = cyc - hs_fall;
            hs_fall = cyc;
        end
        if (!prev_hs && got[3] && hs_fall >= 0) hs_width = cyc - hs_fall;
        if (prev_vs && !got[2]) vs_fall = cyc;
        if (!prev_vs && got[2] && vs_fall >= 0) vs_width = cyc - vs_fall;
        if (got[0]) begin
            if (fs_first < 0) fs_first = cyc;
            fs_prev = fs_last;
            fs_last = cyc;
        end
        prev_hs = got[3];
        prev_vs = got[2];
    endtask

    int wx [9] = '{0, 159, 0, 0, 3, 10, 160, 3, 3};
    int wy [9] = '{0, 119, 5, 6, 0, 20, 5, 120, 5};
    int wc [9] = '{5, 3, 4, 4, 4, 1, 7, 7, 2};

    initial begin
        bit rbw_done = 1'b0;
        int guard    = 0;
        rst_pix.sig = RstSig;
        rst_pix.h   = -1;
        rst_pix.v   = -1;
        rst_pix.act = 1'b0;
        model_reset();
        meas_clear();
        pix_en = 1'b0;
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        #1 resetb = 1'b0;
        #1 check_val("rst_outputs", {25'd0, pins()}, {25'd0, RstSig});

        // Fill the framebuffer with random colours while in reset, then the directed pixels.
        for (int i = 0; i < 19200; i++) begin
            plot   = 1'b1;
            x      = 8'(i % 160);
            y      = 7'(i / 160);
            colour = 3'($urandom);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            x      = 8'(wx[i]);
            y      = 7'(wy[i]);
            colour = 3'(wc[i]);
            tick();
        end
        plot = 1'b0;

        // Frame 1 at full rate; rewrite (10,20) in the same clock that reads it.
        resetb = 1'b1;
        cyc    = 0;
        meas_clear();
        pix_en = 1'b1;
        for (int i = 0; i < 26004; i++) begin
            if (!rbw_done && mh == 10 && mv == 20) begin
                plot     = 1'b1;
                x        = 8'd10;
                y        = 7'd20;
                colour   = 3'd6;
                rbw_done = 1'b1;
            end else begin
                plot = 1'b0;
            end
            tick();
        end
        plot = 1'b0;
        check_val("fs_first", fs_first, 2);
        check_val("fs_period", fs_last - fs_prev, 26000);
        check_val("hs_width", hs_width, 24);
        check_val("hs_period", hs_period, 200);
        check_val("vs_width", vs_width, 400);

        // Frame 2 with random writes, some out of range, until the raster is at (80,60).
        while (!(mh == 80 && mv == 60) && guard < 30000) begin
            plot   = 1'($urandom);
            x      = 8'($urandom_range(0, 200));
            y      = $urandom_range(0, 1) ? 7'($urandom_range(25, 100))
                                          : 7'($urandom_range(120, 127));
            colour = 3'($urandom);
            tick();
            guard++;
        end
        check_val("reach_80_60", {31'd0, (mh == 80 && mv == 60)}, 1);
        plot = 1'b0;

        // Reset in mid-frame: the outputs must follow resetb at once, without a clock.
        resetb = 1'b0;
        #1;
        model_reset();
        check_val("rst_async", {25'd0, pins()}, {25'd0, RstSig});
        repeat (3) tick();
        resetb = 1'b1;
        cyc    = 0;
        meas_clear();
        pix_en = 1'b1;
        repeat (405) tick();
        check_val("fs_after_rst", fs_first, 2);

        // pix_en at half rate: the line period doubles and sync stays aligned with data.
        meas_clear();
        for (int i = 0; i < 1300; i++) begin
            pix_en = (i % 2 == 0);
            tick();
        end
        check_val("hs_period_half", hs_period, 400);
        check_val("hs_width_half", hs_width, 48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
